// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer wrapped around an external combinational ALU.
// Holds an 8 x 8-bit register file and accepts one command at a time. It iterates
// the ALU rep+1 times, writes the result back and returns it on a response handshake.
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [2:0] cmd_rd,
  input  logic [2:0] cmd_rs,
  input  logic [2:0] cmd_rt,
  input  logic       cmd_imm_en,
  input  logic [7:0] cmd_imm,
  input  logic [2:0] cmd_rep,
  output logic [3:0] alu_ctrl,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic [2:0] rsp_rd,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREG = 8;
  localparam int unsigned OPW  = 4;
  localparam int unsigned REPW = 3;

  localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPW-1:0] OP_LOAD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_regs [NREG];
  logic [OPW-1:0]  r_op;
  logic [AW-1:0]   r_rd;
  logic [REPW-1:0] r_rep;
  logic [REPW-1:0] r_iter;
  logic [DW-1:0]   r_opy;
  logic            r_carry_acc;
  // r_alu_x doubles as the accumulator: it is the value fed to the ALU each iteration.
  logic [OPW-1:0]  r_alu_ctrl;
  logic [DW-1:0]   r_alu_x;
  logic [DW-1:0]   r_alu_y;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic            r_rsp_carry;
  logic [AW-1:0]   r_rsp_rd;

  logic            w_accept;
  logic            w_cmd_is_load;
  logic [DW-1:0]   w_opy;
  logic            w_is_addsub;
  logic            w_carry_next;
  logic            w_last;

  // Command decode and per-iteration helpers
  assign cmd_ready     = rst_n & (r_state == S_IDLE);
  assign w_accept      = cmd_valid & cmd_ready;
  assign w_cmd_is_load = (cmd_op == OP_LOAD);
  // LOAD carries its data in cmd_imm regardless of imm_en
  assign w_opy         = (cmd_imm_en | w_cmd_is_load) ? cmd_imm : r_regs[cmd_rt];
  // alu_carry is only meaningful for add/sub
  assign w_is_addsub   = (r_op == OP_ADD) | (r_op == OP_SUB);
  assign w_carry_next  = r_carry_acc | (alu_carry & w_is_addsub);
  assign w_last        = (r_iter == r_rep);

  // Sequencer FSM, register file and registered ALU/response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_op        <= OP_LOAD;
      r_rd        <= '0;
      r_rep       <= '0;
      r_iter      <= '0;
      r_opy       <= '0;
      r_carry_acc <= 1'b0;
      r_alu_ctrl  <= OP_LOAD;
      r_alu_x     <= '0;
      r_alu_y     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_rd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= cmd_op;
            r_rd        <= cmd_rd;
            r_rep       <= cmd_rep;
            r_iter      <= '0;
            r_opy       <= w_opy;
            r_carry_acc <= 1'b0;
            r_state     <= S_EXEC;
            if (!w_cmd_is_load) begin
              r_alu_ctrl <= cmd_op;
              r_alu_x    <= r_regs[cmd_rs];
              r_alu_y    <= w_opy;
            end
          end
        end
        S_EXEC: begin
          if (r_op == OP_LOAD) begin
            r_regs[r_rd] <= r_opy;
            r_rsp_data   <= r_opy;
            r_rsp_carry  <= 1'b0;
            r_rsp_rd     <= r_rd;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_carry_acc <= w_carry_next;
            if (w_last) begin
              r_regs[r_rd] <= alu_out;
              r_rsp_data   <= alu_out;
              r_rsp_carry  <= w_carry_next;
              r_rsp_rd     <= r_rd;
              r_rsp_valid  <= 1'b1;
              r_alu_ctrl   <= OP_LOAD;
              r_alu_x      <= '0;
              r_alu_y      <= '0;
              r_state      <= S_RESP;
            end else begin
              r_iter  <= r_iter + REPW'(1);
              r_alu_x <= alu_out;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_ctrl  = r_alu_ctrl;
  assign alu_x     = r_alu_x;
  assign alu_y     = r_alu_y;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_rd    = r_rsp_rd;
  assign dbg_data  = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: table of directed commands plus hand-written
// sequences for iteration, backpressure and reset-during-execution.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs;
  logic [2:0] cmd_rt;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;
  logic [2:0] cmd_rep;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [2:0] rsp_rd;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] xs [8];

  alu_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .cmd_rep    (cmd_rep),
    .alu_ctrl   (alu_ctrl),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_rd     (rsp_rd),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; logic ops assert carry to show that it is masked
  always_comb begin
    logic [7:0] s;
    s         = 8'h00;
    alu_out   = 8'h00;
    alu_carry = 1'b1;
    case (alu_ctrl)
      4'b0000: begin
        s = alu_x + alu_y; alu_out = s;
        alu_carry = (alu_x[7] == alu_y[7]) && (s[7] != alu_x[7]);
      end
      4'b0001: begin
        s = alu_x - alu_y; alu_out = s;
        alu_carry = (alu_x[7] != alu_y[7]) && (s[7] != alu_x[7]);
      end
      4'b0010: alu_out = alu_x & alu_y;
      4'b0011: alu_out = alu_x | alu_y;
      4'b0100: alu_out = alu_x ^ alu_y;
      default: alu_out = 8'h00;
    endcase
  end

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       imm_en;
    logic [7:0] imm;
    logic [2:0] rep;
    logic [7:0] exp_data;
    logic       exp_carry;
    int         exp_lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Issue one command from a negedge; returns at the negedge where rsp_valid is seen
  task automatic run_cmd(input vec_t v, output int lat);
    int n;
    int nx;
    cmd_op = v.op; cmd_rd = v.rd; cmd_rs = v.rs; cmd_rt = v.rt;
    cmd_imm_en = v.imm_en; cmd_imm = v.imm; cmd_rep = v.rep;
    cmd_valid = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk); n++;
    end
    check("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    nx = 0;
    for (int i = 0; i < 8; i++) xs[i] = 8'h00;
    while (!rsp_valid && lat < 40) begin
      if (nx < 8) xs[nx] = alu_x;
      nx++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic mk(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                    input logic [2:0] rt, input logic imm_en, input logic [7:0] imm,
                    input logic [2:0] rep, output vec_t v);
    v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm_en = imm_en; v.imm = imm; v.rep = rep;
    v.exp_data = 8'h00; v.exp_carry = 1'b0; v.exp_lat = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat;
    logic [7:0] d;
    vec_t v;

    // op, rd, rs, rt, imm_en, imm, rep, exp_data, exp_carry, exp_lat
    vecs[0]  = '{4'hF, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 3'd0, 8'h05, 1'b0, 2};
    vecs[1]  = '{4'hF, 3'd2, 3'd0, 3'd0, 1'b1, 8'h03, 3'd0, 8'h03, 1'b0, 2};
    vecs[2]  = '{4'h0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 3'd0, 8'h08, 1'b0, 2};
    vecs[3]  = '{4'hF, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, 3'd0, 8'h7F, 1'b0, 2};
    vecs[4]  = '{4'h0, 3'd4, 3'd1, 3'd0, 1'b1, 8'h01, 3'd0, 8'h80, 1'b1, 2};
    vecs[5]  = '{4'hF, 3'd1, 3'd0, 3'd0, 1'b1, 8'h10, 3'd0, 8'h10, 1'b0, 2};
    vecs[6]  = '{4'h0, 3'd5, 3'd1, 3'd0, 1'b1, 8'h10, 3'd3, 8'h50, 1'b0, 5};
    vecs[7]  = '{4'hF, 3'd1, 3'd0, 3'd0, 1'b1, 8'h80, 3'd0, 8'h80, 1'b0, 2};
    vecs[8]  = '{4'h1, 3'd7, 3'd1, 3'd0, 1'b1, 8'h01, 3'd1, 8'h7E, 1'b1, 3};
    vecs[9]  = '{4'h4, 3'd6, 3'd5, 3'd4, 1'b0, 8'hFF, 3'd0, 8'hD0, 1'b0, 2};
    vecs[10] = '{4'hD, 3'd2, 3'd1, 3'd0, 1'b1, 8'h33, 3'd0, 8'h00, 1'b0, 2};
    vecs[11] = '{4'hF, 3'd0, 3'd3, 3'd3, 1'b0, 8'h3C, 3'd5, 8'h3C, 1'b0, 2};
    vecs[12] = '{4'h0, 3'd1, 3'd1, 3'd0, 1'b1, 8'h05, 3'd2, 8'h8F, 1'b0, 4};
    vecs[13] = '{4'h1, 3'd7, 3'd0, 3'd1, 1'b0, 8'h00, 3'd0, 8'hAD, 1'b1, 2};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_rd = 3'd0; cmd_rs = 3'd0;
    cmd_rt = 3'd0; cmd_imm_en = 1'b0; cmd_imm = 8'h00; cmd_rep = 3'd0;
    rsp_ready = 1'b1; dbg_addr = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'hF);
    check("rst_alu_xy", {16'h0, alu_x, alu_y}, 32'd0);
    check("rst_rsp", {20'h0, rsp_data, rsp_carry, rsp_rd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      check("rst_reg", 32'(d), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Directed command table
    for (int k = 0; k < 14; k++) begin
      run_cmd(vecs[k], lat);
      check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
      check($sformatf("v%0d_rsp_data", k), 32'(rsp_data), 32'(vecs[k].exp_data));
      check($sformatf("v%0d_rsp_carry", k), 32'(rsp_carry), 32'(vecs[k].exp_carry));
      check($sformatf("v%0d_rsp_rd", k), 32'(rsp_rd), 32'(vecs[k].rd));
      read_reg(vecs[k].rd, d);
      check($sformatf("v%0d_regfile", k), 32'(d), 32'(vecs[k].exp_data));
      @(negedge clk);
      #1;
      check($sformatf("v%0d_ready_after", k), 32'(cmd_ready), 32'd1);
      check($sformatf("v%0d_valid_after", k), 32'(rsp_valid), 32'd0);
    end

    // Repeated ADD: accumulator sequence on alu_x, source register untouched
    mk(4'hF, 3'd1, 3'd0, 3'd0, 1'b1, 8'h10, 3'd0, v);
    run_cmd(v, lat);
    @(negedge clk);
    mk(4'h0, 3'd5, 3'd1, 3'd0, 1'b1, 8'h10, 3'd3, v);
    run_cmd(v, lat);
    check("rep3_x0", 32'(xs[0]), 32'h10);
    check("rep3_x1", 32'(xs[1]), 32'h20);
    check("rep3_x2", 32'(xs[2]), 32'h30);
    check("rep3_x3", 32'(xs[3]), 32'h40);
    check("rep3_latency", 32'(lat), 32'd5);
    check("rep3_data", 32'(rsp_data), 32'h50);
    check("rep3_alu_idle", 32'(alu_ctrl), 32'hF);
    read_reg(3'd1, d);
    check("rep3_r1_unchanged", 32'(d), 32'h10);
    @(negedge clk);

    // Response backpressure
    mk(4'hF, 3'd2, 3'd0, 3'd0, 1'b1, 8'h11, 3'd0, v);
    run_cmd(v, lat);
    @(negedge clk);
    rsp_ready = 1'b0;
    mk(4'h0, 3'd2, 3'd2, 3'd0, 1'b1, 8'h22, 3'd0, v);
    run_cmd(v, lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h33);
      check("bp_rd", 32'(rsp_rd), 32'd2);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_alu_ctrl", 32'(alu_ctrl), 32'hF);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    check("bp_ready_back", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a long XOR
    mk(4'hF, 3'd6, 3'd0, 3'd0, 1'b1, 8'hAA, 3'd0, v);
    run_cmd(v, lat);
    check("ld_r6", 32'(rsp_data), 32'hAA);
    @(negedge clk);
    cmd_op = 4'h4; cmd_rd = 3'd6; cmd_rs = 3'd6; cmd_rt = 3'd0;
    cmd_imm_en = 1'b1; cmd_imm = 8'hFF; cmd_rep = 3'd7;
    cmd_valid = 1'b1;
    #1;
    check("rx_accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rx_in_exec", 32'(alu_ctrl), 32'h4);
    check("rx_exec_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rx_ready_in_rst", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rx_ready_after", 32'(cmd_ready), 32'd1);
    check("rx_alu_ctrl", 32'(alu_ctrl), 32'hF);
    read_reg(3'd6, d);
    check("rx_r6_cleared", 32'(d), 32'h00);
    read_reg(3'd1, d);
    check("rx_r1_cleared", 32'(d), 32'h00);
    for (int c = 0; c < 12; c++) begin
      check("rx_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    read_reg(3'd6, d);
    check("rx_r6_no_wb", 32'(d), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Command sequencer that owns the 8-bit ALU and sits between a host command port and the combinational ALU instance. It holds an 8-entry register file, accepts one command at a time over a valid/ready handshake, and drives the ALU for one or more iterations. It writes the final result back to the register file and returns it, together with an overflow flag, on a response handshake.

## Interface
- No parameters. Fixed at 8 registers × 8 bits and 3-bit register addresses.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  4  ALU ctrl code; 4'b1111 = LOAD (not sent to ALU)
- cmd_rd  in  3  destination register
- cmd_rs  in  3  x-operand register
- cmd_rt  in  3  y-operand register
- cmd_imm_en  in  1  1: y operand = cmd_imm; 0: y operand = R[cmd_rt]
- cmd_imm  in  8  immediate; LOAD data
- cmd_rep  in  3  extra iterations; the operation executes cmd_rep+1 times
- alu_ctrl  out  4  to ALU ctrl
- alu_x  out  8  to ALU x
- alu_y  out  8  to ALU y
- alu_out  in  8  from ALU out
- alu_carry  in  1  from ALU carry (signed overflow for add/sub)
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_data  out  8  value written to R[rd]
- rsp_carry  out  1  sticky OR of captured carries
- rsp_rd  out  3  destination register of the response
- dbg_addr  in  3  register file read address
- dbg_data  out  8  R[dbg_addr], combinational

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch op, rd and rep. Set acc ← R[rs], opy ← (imm_en ? imm : R[rt]), iter ← 0, carry_acc ← 0.
  - Go to EXEC.
- EXEC, ALU ops:
  - Drive alu_ctrl = op, alu_x = acc, alu_y = opy.
  - Each cycle: acc ← alu_out; carry_acc ← carry_acc | (alu_carry & (op==4'b0000 | op==4'b0001)). For all other ops, alu_carry is ignored because it is undefined.
  - If iter == rep: write R[rd] ← alu_out, load the response registers, go to RESP. Otherwise iter ← iter+1.
- EXEC, LOAD (op 4'b1111):
  - Exactly one cycle; rep is ignored.
  - R[rd] ← cmd_imm latched value, rsp_data = imm, rsp_carry = 0.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_carry and rsp_rd are held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
- Outside EXEC: alu_ctrl = 4'b1111, alu_x = 0, alu_y = 0.
- Register reads: operands are sampled once, at the acceptance edge. rd may equal rs or rt; there are no hazards because only one command is in flight.
- Unused ctrl codes 1101/1110 pass through to the ALU; the result is written as returned (0).
- All arithmetic is 8-bit modulo; acc wraps.

## Timing
- Command accepted at edge T.
- EXEC cycles are T+1 … T+1+rep; the R[rd] write occurs at the end of the last EXEC cycle.
- rsp_valid rises in cycle T+2+rep; this is the minimum latency (2 cycles for rep=0 and for LOAD).
- cmd_ready is 0 from T+1 until the cycle after the response handshake. Back-to-back throughput is one command per rep+3 cycles.
- rsp_valid & rsp_ready in cycle R → IDLE in R+1.
- Reset values (rst_n low at an edge): state IDLE, all R[i] = 0, acc/opy/iter = 0, rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rsp_rd = 0, alu_ctrl = 4'b1111, alu_x = alu_y = 0.
  - cmd_ready is forced to 0 while rst_n is low.
- Reset mid-EXEC or mid-RESP: the command is discarded, there is no writeback and no response, and the register file is cleared.
- cmd_valid while not ready: ignored; the host must hold it.

## Test plan
- LOAD R1=0x05; LOAD R2=0x03; ADD(0000) rd=3, rs=1, rt=2, rep=0 → rsp_data=0x08, rsp_carry=0, rsp_rd=3, rsp_valid two cycles after acceptance; dbg_addr=3 reads 0x08.
- LOAD R1=0x7F; ADD imm 0x01 rd=4, rs=1 → rsp_data=0x80, rsp_carry=1.
- LOAD R1=0x10; ADD imm 0x10 rep=3 rd=5, rs=1 → alu_x sequence 0x10, 0x20, 0x30, 0x40 over 4 EXEC cycles; rsp_data=0x50; rsp_valid at T+5; R1 unchanged (0x10).
- LOAD R1=0x80; SUB(0001) imm 0x01 rep=1 → iterations 0x7F (carry), 0x7E (no carry); rsp_data=0x7E, rsp_carry=1 (sticky).
- Response backpressure: rsp_ready low for 5 cycles → rsp_valid/rsp_data stable, cmd_ready=0, alu_ctrl=4'b1111; accepted on the first high cycle, cmd_ready=1 the next cycle.
- Reset during EXEC of rep=7 (LOAD R6=0xAA first, then XOR into R6) → no rsp_valid; R6 reads 0x00 after reset; cmd_ready=1 on the first cycle with rst_n high.
